fetch_alu_core: RTL and testbench
=================================

FETCH_ALU_CORE -- requirements
Module: fetch_alu_core

Interface
Parameters:
REQ-001 WIDTH, 32, datapath and instruction width in bits.
REQ-002 IMEM_DEPTH, 256, instruction memory depth in words; power of two.
REQ-003 IMEM_INIT, "" (empty), hex file loaded into instruction memory at elaboration; when empty, contents are zero.

Ports:
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 pc_enable  in  1  advances the PC this cycle.
REQ-007 take_branch  in  1  selects the branch target instead of PC+1.
REQ-008 is_relative_branch  in  1  1: target is PC+branch_addr; 0: target is branch_addr.
REQ-009 branch_addr  in  WIDTH  branch offset or absolute target.
REQ-010 pc_out  out  WIDTH  current PC, as a word index.
REQ-011 imem_we  in  1  instruction memory write enable.
REQ-012 imem_waddr  in  WIDTH  write word address.
REQ-013 imem_wdata  in  WIDTH  write data.
REQ-014 inst  out  WIDTH  fetched instruction (registered).
REQ-015 alu_opcode  in  5  ALU operation select.
REQ-016 alu_cc  in  3  compare condition code.
REQ-017 alu_data_a  in  WIDTH  operand A.
REQ-018 alu_data_b  in  WIDTH  operand B.
REQ-019 alu_data_z  out  WIDTH  ALU result (combinational).

Function
PC controller:
REQ-020 On a rising edge with pc_enable=0, pc_out SHALL hold; take_branch and branch_addr are ignored.
REQ-021 On a rising edge with pc_enable=1 and take_branch=0, pc_out SHALL become pc_out+1.
REQ-022 On a rising edge with pc_enable=1, take_branch=1 and is_relative_branch=1, pc_out SHALL become pc_out+branch_addr (two's complement, so negative offsets branch backward).
REQ-023 On a rising edge with pc_enable=1, take_branch=1 and is_relative_branch=0, pc_out SHALL become branch_addr.
REQ-024 All PC arithmetic SHALL wrap modulo 2^WIDTH; there is no overflow flag.

Instruction memory:
REQ-025 Every rising edge, inst SHALL load mem[pc_out mod IMEM_DEPTH], giving one-cycle read latency after any PC change.
REQ-026 When imem_we=1, mem[imem_waddr mod IMEM_DEPTH] SHALL be written with imem_wdata on the rising edge.
REQ-027 A same-cycle read and write to the same address SHALL return the old data on inst; the new data appears on the next read.

ALU (combinational, WIDTH bits):
REQ-028 Opcode encoding SHALL be:
- 0 NOP: z=0
- 1 MOV: z=a
- 2 ADD: z=a+b
- 3 SUB: z=a-b
- 4 AND: z=a&b
- 5 OR: z=a|b
- 6 XOR: z=a^b
- 7 SHL: z=a<<b[4:0]
- 8 SHR: logical right shift, z=a>>b[4:0]
- 9 CMP: compare, see REQ-029
- 10 BR: z=a
- 11-31: z=0
REQ-029 CMP SHALL produce z=1 if the condition holds, else z=0, zero-extended to WIDTH, with alu_cc encoded as:
- 0 EQ, 1 NE
- 2 LT, 3 LE, 4 GT, 5 GE (signed)
- 6 LTU, 7 GEU (unsigned)
REQ-030 ADD and SUB SHALL wrap modulo 2^WIDTH; there is no carry output.

Reset
REQ-031 While reset=1, pc_out=0 and inst=0 SHALL hold immediately, independent of clk.
REQ-032 Reset SHALL NOT clear memory contents.
REQ-033 After reset deasserts, the first rising edge SHALL fetch mem[0] into inst; pc_out SHALL then advance only per REQ-020..023.
REQ-034 Reset asserted mid-operation SHALL override pc_enable, take_branch and imem_we on that edge.

Verification
REQ-035 Memory preloaded with mem[i]=i+0x100; reset, then pc_enable=1 for 4 cycles -> pc_out 0,1,2,3,4; inst lags pc_out by one cycle (0x100, 0x101, ...).
REQ-036 pc_out=10, pc_enable=1, take_branch=1, is_relative_branch=1, branch_addr=0xFFFFFFFD -> pc_out=7. With is_relative_branch=0 and branch_addr=0x20 -> pc_out=0x20.
REQ-037 pc_enable=0 with take_branch=1 for 3 cycles -> pc_out unchanged. pc_out=0xFFFFFFFF with pc_enable=1 -> pc_out wraps to 0.
REQ-038 ALU: ADD 0xFFFFFFFF+1 -> 0; SUB 3-5 -> 0xFFFFFFFE; CMP LT with a=0xFFFFFFFF, b=1 -> 1; CMP LTU on the same operands -> 0; SHL 1 by 31 -> 0x80000000; opcode 20 -> 0.
REQ-039 Write 0xDEADBEEF to address 0x103 (IMEM_DEPTH=256), then run the PC to 3 -> inst=0xDEADBEEF one cycle later.
REQ-040 Assert reset asynchronously mid-run between clock edges -> pc_out=0 and inst=0 before the next clk edge; memory contents are preserved.

Source files
------------

// File: rtl/fetch_alu_core_if.sv
// Bus bundle for fetch_alu_core: PC control, instruction-memory write port,
// fetched instruction and the combinational ALU operands/result.
//
// Qualifier semantics (no valid/ready pairs on this bus): pc_enable and
// imem_we are single-cycle qualifiers sampled on the rising clock edge. Every
// other input is a don't-care unless its qualifier is high on that edge, except
// the ALU operands, which are sampled continuously because the ALU has no state.
interface fetch_alu_core_if #(
    parameter int WIDTH = 32
);
    // PC controller
    logic             pc_enable;
    logic             take_branch;
    logic             is_relative_branch;
    logic [WIDTH-1:0] branch_addr;
    logic [WIDTH-1:0] pc_out;

    // Instruction memory
    logic             imem_we;
    logic [WIDTH-1:0] imem_waddr;
    logic [WIDTH-1:0] imem_wdata;
    logic [WIDTH-1:0] inst;

    // ALU
    logic [4:0]       alu_opcode;
    logic [2:0]       alu_cc;
    logic [WIDTH-1:0] alu_data_a;
    logic [WIDTH-1:0] alu_data_b;
    logic [WIDTH-1:0] alu_data_z;

    // The side that controls the core (sequencer or testbench).
    modport master (
        output pc_enable, take_branch, is_relative_branch, branch_addr,
        output imem_we, imem_waddr, imem_wdata,
        output alu_opcode, alu_cc, alu_data_a, alu_data_b,
        input  pc_out, inst, alu_data_z
    );

    // The core itself.
    modport slave (
        input  pc_enable, take_branch, is_relative_branch, branch_addr,
        input  imem_we, imem_waddr, imem_wdata,
        input  alu_opcode, alu_cc, alu_data_a, alu_data_b,
        output pc_out, inst, alu_data_z
    );
endinterface

// File: rtl/fetch_alu_core.sv
// fetch_alu_core: program counter with relative/absolute branching, a
// single-port-read / single-port-write instruction memory with a registered
// fetch, and a purely combinational ALU. The three parts share only the clock
// and reset; the PC feeds the memory read address.
module fetch_alu_core #(
    parameter int    WIDTH      = 32,
    parameter int    IMEM_DEPTH = 256,
    parameter string IMEM_INIT  = ""
) (
    input  logic              clk,
    input  logic              reset,
    fetch_alu_core_if.slave   bus
);

    localparam int AW = $clog2(IMEM_DEPTH);

    // ALU opcode encoding
    localparam logic [4:0] OP_NOP = 5'd0;
    localparam logic [4:0] OP_MOV = 5'd1;
    localparam logic [4:0] OP_ADD = 5'd2;
    localparam logic [4:0] OP_SUB = 5'd3;
    localparam logic [4:0] OP_AND = 5'd4;
    localparam logic [4:0] OP_OR  = 5'd5;
    localparam logic [4:0] OP_XOR = 5'd6;
    localparam logic [4:0] OP_SHL = 5'd7;
    localparam logic [4:0] OP_SHR = 5'd8;
    localparam logic [4:0] OP_CMP = 5'd9;
    localparam logic [4:0] OP_BR  = 5'd10;

    // Compare condition codes
    localparam logic [2:0] CC_EQ  = 3'd0;
    localparam logic [2:0] CC_NE  = 3'd1;
    localparam logic [2:0] CC_LT  = 3'd2;
    localparam logic [2:0] CC_LE  = 3'd3;
    localparam logic [2:0] CC_GT  = 3'd4;
    localparam logic [2:0] CC_GE  = 3'd5;
    localparam logic [2:0] CC_LTU = 3'd6;
    localparam logic [2:0] CC_GEU = 3'd7;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // PC controller
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] w_pc_inc;
    logic [WIDTH-1:0] w_pc_rel;
    logic [WIDTH-1:0] w_pc_target;
    logic [WIDTH-1:0] w_pc_next;

    // Both adders wrap modulo 2^WIDTH; a negative offset in two's complement
    // therefore branches backward without any special handling.
    assign w_pc_inc    = r_pc + ONE;
    assign w_pc_rel    = r_pc + bus.branch_addr;
    assign w_pc_target = bus.is_relative_branch ? w_pc_rel : bus.branch_addr;
    assign w_pc_next   = bus.take_branch ? w_pc_target : w_pc_inc;

    // PC register: reset to word 0, otherwise advance only when enabled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc <= '0;
        end else if (bus.pc_enable) begin
            r_pc <= w_pc_next;
        end
    end

    assign bus.pc_out = r_pc;

    // ------------------------------------------------------------------
    // Instruction memory
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] r_mem [IMEM_DEPTH];
    logic [WIDTH-1:0] r_inst;
    logic [AW-1:0]    w_rd_addr;
    logic [AW-1:0]    w_wr_addr;
    logic             w_wr_en;
    logic             w_unused_waddr;

    // Addresses wrap onto the memory depth by dropping the upper bits.
    assign w_rd_addr      = r_pc[AW-1:0];
    assign w_wr_addr      = bus.imem_waddr[AW-1:0];
    assign w_unused_waddr = &{1'b0, bus.imem_waddr[WIDTH-1:AW]};

    // A write is suppressed while reset is held so that reset asserted on
    // a clock edge wins over imem_we without clearing the array.
    assign w_wr_en = bus.imem_we & ~reset;

    // The array powers up as zero.
    initial begin
        for (int i = 0; i < IMEM_DEPTH; i++) begin
            r_mem[i] = '0;
        end
    end

    // Memory write port; the array itself is never reset.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_addr] <= bus.imem_wdata;
        end
    end

    // Registered fetch: nonblocking read sees the pre-write contents, so a
    // same-edge write to the fetched address returns the old word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_inst <= '0;
        end else begin
            r_inst <= r_mem[w_rd_addr];
        end
    end

    assign bus.inst = r_inst;

    // ------------------------------------------------------------------
    // ALU
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [4:0]       w_shamt;
    logic             w_eq;
    logic             w_lt_s;
    logic             w_lt_u;
    logic             w_cmp;
    logic [WIDTH-1:0] w_z;

    assign w_a     = bus.alu_data_a;
    assign w_b     = bus.alu_data_b;
    assign w_shamt = w_b[4:0];
    assign w_eq    = (w_a == w_b);
    assign w_lt_s  = ($signed(w_a) < $signed(w_b));
    assign w_lt_u  = (w_a < w_b);

    // Condition evaluation for CMP; LE/GT/GE are derived from EQ and LT.
    always_comb begin
        w_cmp = 1'b0;
        case (bus.alu_cc)
            CC_EQ:   w_cmp = w_eq;
            CC_NE:   w_cmp = ~w_eq;
            CC_LT:   w_cmp = w_lt_s;
            CC_LE:   w_cmp = w_lt_s | w_eq;
            CC_GT:   w_cmp = ~(w_lt_s | w_eq);
            CC_GE:   w_cmp = ~w_lt_s;
            CC_LTU:  w_cmp = w_lt_u;
            CC_GEU:  w_cmp = ~w_lt_u;
            default: w_cmp = 1'b0;
        endcase
    end

    // Result select; unassigned opcodes (11-31) and NOP produce zero.
    always_comb begin
        w_z = '0;
        case (bus.alu_opcode)
            OP_NOP:  w_z = '0;
            OP_MOV:  w_z = w_a;
            OP_ADD:  w_z = w_a + w_b;
            OP_SUB:  w_z = w_a - w_b;
            OP_AND:  w_z = w_a & w_b;
            OP_OR:   w_z = w_a | w_b;
            OP_XOR:  w_z = w_a ^ w_b;
            OP_SHL:  w_z = w_a << w_shamt;
            OP_SHR:  w_z = w_a >> w_shamt;
            OP_CMP:  w_z = {{(WIDTH-1){1'b0}}, w_cmp};
            OP_BR:   w_z = w_a;
            default: w_z = '0;
        endcase
    end

    assign bus.alu_data_z = w_z;

endmodule

// File: tb/tb_fetch_alu_core.sv
// Bench for fetch_alu_core: ALU vector table plus random ALU operands against
// an arithmetic reference, directed PC/memory/reset sequences, and a random
// PC/memory run against a cycle-level model of PC, fetch register and array.
module tb_fetch_alu_core;

    localparam int WIDTH = 32;
    localparam int DEPTH = 256;

    logic clk;
    logic reset;

    fetch_alu_core_if #(.WIDTH(WIDTH)) bus ();

    fetch_alu_core #(
        .WIDTH      (WIDTH),
        .IMEM_DEPTH (DEPTH),
        .IMEM_INIT  ("")
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard counters ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [WIDTH-1:0] act,
                         input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [WIDTH-1:0] m_mem [DEPTH];
    logic [WIDTH-1:0] m_pc;
    logic [WIDTH-1:0] m_inst;

    function automatic longint as_signed(input logic [31:0] v);
        longint u;
        u = longint'(v);
        return (u >= 64'sd2147483648) ? u - 64'sd4294967296 : u;
    endfunction

    function automatic logic [31:0] ref_alu(input logic [4:0] op, input logic [2:0] cc,
                                            input logic [31:0] a, input logic [31:0] b);
        longint ua, ub, sa, sb;
        longint r;
        bit c;
        ua = longint'(a);
        ub = longint'(b);
        sa = as_signed(a);
        sb = as_signed(b);
        r = 0;
        case (op)
            5'd1:    r = ua;
            5'd2:    r = (ua + ub) % 64'sd4294967296;
            5'd3:    r = (ua - ub + 64'sd4294967296) % 64'sd4294967296;
            5'd4:    r = longint'(a & b);
            5'd5:    r = longint'(a | b);
            5'd6:    r = longint'(a ^ b);
            5'd7:    r = (ua * (64'sd1 << (ub % 32))) % 64'sd4294967296;
            5'd8:    r = ua / (64'sd1 << (ub % 32));
            5'd9: begin
                case (cc)
                    3'd0: c = (ua == ub);
                    3'd1: c = (ua != ub);
                    3'd2: c = (sa < sb);
                    3'd3: c = (sa <= sb);
                    3'd4: c = (sa > sb);
                    3'd5: c = (sa >= sb);
                    3'd6: c = (ua < ub);
                    default: c = (ua >= ub);
                endcase
                r = c ? 1 : 0;
            end
            5'd10:   r = ua;
            default: r = 0;
        endcase
        return r[31:0];
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive_pc(input logic en, input logic tb_take, input logic rel,
                            input logic [WIDTH-1:0] addr);
        bus.pc_enable          = en;
        bus.take_branch        = tb_take;
        bus.is_relative_branch = rel;
        bus.branch_addr        = addr;
    endtask

    task automatic drive_wr(input logic we, input logic [WIDTH-1:0] addr,
                            input logic [WIDTH-1:0] data);
        bus.imem_we    = we;
        bus.imem_waddr = addr;
        bus.imem_wdata = data;
    endtask

    // One rising edge: update the model from the driven inputs, then compare
    // PC and fetched word 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        if (reset) begin
            m_pc   = '0;
            m_inst = '0;
        end else begin
            m_inst = m_mem[m_pc % DEPTH];
            if (bus.pc_enable) begin
                if (!bus.take_branch)            m_pc = m_pc + 1;
                else if (bus.is_relative_branch) m_pc = m_pc + bus.branch_addr;
                else                             m_pc = bus.branch_addr;
            end
            if (bus.imem_we) m_mem[bus.imem_waddr % DEPTH] = bus.imem_wdata;
        end
        #1;
        check("pc_model", bus.pc_out, m_pc);
        check("inst_model", bus.inst, m_inst);
    endtask

    // ---------------- ALU vector table ----------------
    typedef struct {
        logic [4:0]  op;
        logic [2:0]  cc;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] z;
    } alu_vec_t;

    alu_vec_t alu_tab [20];

    initial begin
        logic [WIDTH-1:0] saved;

        alu_tab[0]  = '{5'd2,  3'd0, 32'hFFFF_FFFF, 32'h1,         32'h0};
        alu_tab[1]  = '{5'd3,  3'd0, 32'h3,         32'h5,         32'hFFFF_FFFE};
        alu_tab[2]  = '{5'd9,  3'd2, 32'hFFFF_FFFF, 32'h1,         32'h1};
        alu_tab[3]  = '{5'd9,  3'd6, 32'hFFFF_FFFF, 32'h1,         32'h0};
        alu_tab[4]  = '{5'd7,  3'd0, 32'h1,         32'd31,        32'h8000_0000};
        alu_tab[5]  = '{5'd20, 3'd0, 32'h1234_5678, 32'h1,         32'h0};
        alu_tab[6]  = '{5'd0,  3'd0, 32'hAAAA_AAAA, 32'h5555_5555, 32'h0};
        alu_tab[7]  = '{5'd1,  3'd0, 32'hCAFE_F00D, 32'h1,         32'hCAFE_F00D};
        alu_tab[8]  = '{5'd4,  3'd0, 32'hF0F0_FFFF, 32'h0FF0_1234, 32'h00F0_1234};
        alu_tab[9]  = '{5'd5,  3'd0, 32'hF000_0000, 32'h0000_000F, 32'hF000_000F};
        alu_tab[10] = '{5'd6,  3'd0, 32'hFFFF_0000, 32'hFF00_FF00, 32'h00FF_FF00};
        alu_tab[11] = '{5'd8,  3'd0, 32'h8000_0000, 32'h0000_0024, 32'h0800_0000};
        alu_tab[12] = '{5'd10, 3'd0, 32'h0000_00AB, 32'h7,         32'h0000_00AB};
        alu_tab[13] = '{5'd9,  3'd0, 32'h7,         32'h7,         32'h1};
        alu_tab[14] = '{5'd9,  3'd1, 32'h7,         32'h7,         32'h0};
        alu_tab[15] = '{5'd9,  3'd3, 32'h8000_0000, 32'h8000_0000, 32'h1};
        alu_tab[16] = '{5'd9,  3'd4, 32'h1,         32'hFFFF_FFFF, 32'h1};
        alu_tab[17] = '{5'd9,  3'd5, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0};
        alu_tab[18] = '{5'd9,  3'd7, 32'hFFFF_FFFF, 32'h1,         32'h1};
        alu_tab[19] = '{5'd31, 3'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0};

        // ---------- reset state ----------
        reset = 1'b1;
        drive_pc(1'b0, 1'b0, 1'b0, '0);
        drive_wr(1'b0, '0, '0);
        bus.alu_opcode = '0;
        bus.alu_cc     = '0;
        bus.alu_data_a = '0;
        bus.alu_data_b = '0;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        m_pc   = '0;
        m_inst = '0;
        #2;
        check("reset_pc", bus.pc_out, 32'h0);
        check("reset_inst", bus.inst, 32'h0);
        step();
        reset = 1'b0;

        // ---------- ALU table ----------
        for (int i = 0; i < 20; i++) begin
            bus.alu_opcode = alu_tab[i].op;
            bus.alu_cc     = alu_tab[i].cc;
            bus.alu_data_a = alu_tab[i].a;
            bus.alu_data_b = alu_tab[i].b;
            #1;
            check($sformatf("alu_tab%0d", i), bus.alu_data_z, alu_tab[i].z);
        end

        // ---------- ALU random vs reference ----------
        for (int i = 0; i < 300; i++) begin
            bus.alu_opcode = 5'($urandom_range(0, 15));
            bus.alu_cc     = 3'($urandom_range(0, 7));
            bus.alu_data_a = $urandom;
            bus.alu_data_b = ($urandom_range(0, 3) == 0) ? bus.alu_data_a : $urandom;
            #1;
            check("alu_rand", bus.alu_data_z,
                  ref_alu(bus.alu_opcode, bus.alu_cc, bus.alu_data_a, bus.alu_data_b));
        end

        // ---------- preload mem[i] = i + 0x100 ----------
        for (int i = 0; i < DEPTH; i++) begin
            drive_wr(1'b1, WIDTH'(i), WIDTH'(i + 32'h100));
            step();
        end
        drive_wr(1'b0, '0, '0);

        // ---------- reset held over an edge overrides enable/branch/write ----------
        reset = 1'b1;
        #1;
        check("rst_async_pc", bus.pc_out, 32'h0);
        check("rst_async_inst", bus.inst, 32'h0);
        drive_pc(1'b1, 1'b1, 1'b0, 32'h40);
        drive_wr(1'b1, 32'h5, 32'h0000_0BAD);
        step();
        check("rst_edge_pc", bus.pc_out, 32'h0);
        reset = 1'b0;
        drive_wr(1'b0, '0, '0);

        // ---------- sequential fetch: inst lags pc by one ----------
        drive_pc(1'b1, 1'b0, 1'b0, '0);
        for (int k = 1; k <= 5; k++) begin
            step();
            check("seq_pc", bus.pc_out, WIDTH'(k));
            check("seq_inst", bus.inst, WIDTH'(32'h100 + k - 1));
        end
        drive_pc(1'b0, 1'b0, 1'b0, '0);
        step();
        check("rst_blocked_write", bus.inst, 32'h105);

        // ---------- branches ----------
        drive_pc(1'b1, 1'b1, 1'b0, 32'd10);
        step();
        check("abs_to_10", bus.pc_out, 32'd10);
        drive_pc(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFD);
        step();
        check("rel_back_3", bus.pc_out, 32'd7);
        check("rel_back_inst", bus.inst, 32'h10A);
        drive_pc(1'b1, 1'b1, 1'b0, 32'h20);
        step();
        check("abs_to_20", bus.pc_out, 32'h20);

        // ---------- hold with take_branch high ----------
        drive_pc(1'b0, 1'b1, 1'b0, 32'h55);
        for (int k = 0; k < 3; k++) begin
            step();
            check("hold_pc", bus.pc_out, 32'h20);
        end

        // ---------- PC wrap ----------
        drive_pc(1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF);
        step();
        check("pc_max", bus.pc_out, 32'hFFFF_FFFF);
        drive_pc(1'b1, 1'b0, 1'b0, '0);
        step();
        check("pc_wrap", bus.pc_out, 32'h0);
        check("pc_max_inst", bus.inst, 32'h1FF);

        // ---------- write via aliased address, then fetch ----------
        drive_pc(1'b0, 1'b0, 1'b0, '0);
        drive_wr(1'b1, 32'h103, 32'hDEAD_BEEF);
        step();
        drive_wr(1'b0, '0, '0);
        drive_pc(1'b1, 1'b1, 1'b0, 32'h3);
        step();
        check("run_to_3", bus.pc_out, 32'h3);
        drive_pc(1'b0, 1'b0, 1'b0, '0);
        step();
        check("alias_write_inst", bus.inst, 32'hDEAD_BEEF);

        // ---------- same-edge read/write returns old data ----------
        drive_wr(1'b1, 32'h3, 32'h1234_5678);
        step();
        check("rw_old", bus.inst, 32'hDEAD_BEEF);
        drive_wr(1'b0, '0, '0);
        step();
        check("rw_new", bus.inst, 32'h1234_5678);

        // ---------- random PC / memory run ----------
        for (int i = 0; i < 400; i++) begin
            drive_pc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0),
                     1'($urandom_range(0, 1)),
                     ($urandom_range(0, 1) != 0) ? WIDTH'($urandom_range(0, 300))
                                                 : WIDTH'(-$urandom_range(1, 20)));
            drive_wr(1'($urandom_range(0, 2) == 0), $urandom, $urandom);
            step();
        end
        drive_pc(1'b0, 1'b0, 1'b0, '0);
        drive_wr(1'b0, '0, '0);

        // ---------- async reset between edges; memory survives ----------
        saved = m_mem[9];
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_pc", bus.pc_out, 32'h0);
        check("mid_rst_inst", bus.inst, 32'h0);
        m_pc   = '0;
        m_inst = '0;
        step();
        reset = 1'b0;
        drive_pc(1'b1, 1'b1, 1'b0, 32'h109);
        step();
        drive_pc(1'b0, 1'b0, 1'b0, '0);
        step();
        check("mem_preserved", bus.inst, saved);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
